// File: rtl/cic_pkg.sv
// Shared constants and width helpers for the I/Q CIC decimator.
package cic_pkg;

  // Integrator/comb order of the filter.
  localparam int N_STAGES = 3;

  // Default configuration: R = 64, 20-bit mixer products in, 16-bit out.
  localparam int DEF_LOG2_DECIM = 6;
  localparam int DEF_IN_W       = 20;
  localparam int DEF_OUT_W      = 16;

  // Register growth of an N-stage, M=1 CIC is N*log2(R) bits.
  function automatic int acc_width(input int in_w, input int log2_decim);
    return in_w + N_STAGES * log2_decim;
  endfunction

  // Right shift that maps the full accumulator range onto the output width.
  function automatic int shift_width(input int in_w, input int out_w, input int log2_decim);
    return acc_width(in_w, log2_decim) - out_w;
  endfunction

endpackage

// File: rtl/cic_channel.sv
// One CIC channel: pipelined integrators at the input rate, combs and the
// output truncation at the decimated rate. Stage enables come from the shared
// strobe pipeline in the top so that I and Q stay sample-aligned.
module cic_channel
  import cic_pkg::*;
#(
  parameter int LOG2_DECIM = DEF_LOG2_DECIM,
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    smp_vld_i,
  input  logic signed [IN_W-1:0]  x_i,
  input  logic [N_STAGES-1:0]     comb_en_i,
  input  logic                    out_en_i,
  output logic signed [OUT_W-1:0] y_o
);

  localparam int ACC_W = acc_width(IN_W, LOG2_DECIM);
  localparam int SHIFT = shift_width(IN_W, OUT_W, LOG2_DECIM);

  logic [ACC_W-1:0]                x_ext;
  logic [N_STAGES-1:0][ACC_W-1:0]  integ_q, integ_d;
  logic [N_STAGES-1:0][ACC_W-1:0]  comb_q,  comb_d;
  logic [N_STAGES-1:0][ACC_W-1:0]  dly_q,   dly_d;
  logic [OUT_W-1:0]                y_q,     y_d;

  assign x_ext = {{(ACC_W-IN_W){x_i[IN_W-1]}}, x_i};

  // Integrators: each stage adds the previous stage's registered value, so the
  // chain is pipelined; modular wrap is intentional and cancelled by the combs.
  always_comb begin
    integ_d = integ_q;
    if (smp_vld_i) begin
      integ_d[0] = integ_q[0] + x_ext;
      for (int s = 1; s < N_STAGES; s++)
        integ_d[s] = integ_q[s] + integ_q[s-1];
    end
  end

  // Combs: stage s fires when the decimation strobe reaches it; its delay
  // register holds the previous decimated input of that same stage.
  always_comb begin
    comb_d = comb_q;
    dly_d  = dly_q;
    if (comb_en_i[0]) begin
      comb_d[0] = integ_q[N_STAGES-1] - dly_q[0];
      dly_d[0]  = integ_q[N_STAGES-1];
    end
    for (int s = 1; s < N_STAGES; s++) begin
      if (comb_en_i[s]) begin
        comb_d[s] = comb_q[s-1] - dly_q[s];
        dly_d[s]  = comb_q[s-1];
      end
    end
  end

  // Output: keep the top OUT_W bits (floor arithmetic shift), hold between strobes.
  always_comb begin
    y_d = y_q;
    if (out_en_i)
      y_d = comb_q[N_STAGES-1][ACC_W-1:SHIFT];
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_q <= '0;
      comb_q  <= '0;
      dly_q   <= '0;
      y_q     <= '0;
    end else begin
      integ_q <= integ_d;
      comb_q  <= comb_d;
      dly_q   <= dly_d;
      y_q     <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/cic_decimator.sv
// Dual-channel (I/Q) 3-stage CIC decimator by 2^LOG2_DECIM. One shared sample
// counter and strobe pipeline drive two identical channel datapaths.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int LOG2_DECIM = DEF_LOG2_DECIM,
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_i,
  input  logic signed [IN_W-1:0]  in_q,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_i,
  output logic signed [OUT_W-1:0] out_q
);

  // Strobe pipeline: [0] decimation strobe, [1..N] comb stages done, [N+1] output.
  localparam int STAGES = N_STAGES + 1;

  logic [LOG2_DECIM-1:0]          cnt_q, cnt_d;
  logic [STAGES:0]                vld_pipe_q, vld_pipe_d;
  logic                           frame_end;
  logic [1:0][IN_W-1:0]           ch_x;
  logic [1:0][OUT_W-1:0]          ch_y;

  // R is a power of two, so the counter wraps to 0 naturally after R-1.
  always_comb begin
    frame_end  = in_valid && (cnt_q == '1);
    cnt_d      = in_valid ? cnt_q + LOG2_DECIM'(1) : cnt_q;
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], frame_end};
  end

  // Counter and strobe pipeline; the pipeline advances regardless of in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign ch_x[0] = in_i;
  assign ch_x[1] = in_q;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    cic_channel #(
      .LOG2_DECIM (LOG2_DECIM),
      .IN_W       (IN_W),
      .OUT_W      (OUT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .smp_vld_i  (in_valid),
      .x_i        (ch_x[ch]),
      .comb_en_i  (vld_pipe_q[N_STAGES-1:0]),
      .out_en_i   (vld_pipe_q[N_STAGES]),
      .y_o        (ch_y[ch])
    );
  end

  assign out_valid = vld_pipe_q[STAGES];
  assign out_i     = ch_y[0];
  assign out_q     = ch_y[1];

endmodule

// File: doc/cic_decimator.md
CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 Parameter LOG2_DECIM, default 6, log2 of decimation ratio R (R = 64).
REQ-002 Parameter IN_W, default 20, I/Q input width, matching mixer product width.
REQ-003 Parameter OUT_W, default 16, I/Q output width.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  qualifies in_i/in_q; high every clock when mixer free-runs.
REQ-007 in_i  input  IN_W  signed I sample from mixer.
REQ-008 in_q  input  IN_W  signed Q sample from mixer.
REQ-009 out_valid  output  1  one-cycle strobe, out_i/out_q valid.
REQ-010 out_i  output  OUT_W  signed decimated I.
REQ-011 out_q  output  OUT_W  signed decimated Q.

Function
REQ-012 The block SHALL implement a 3-stage CIC decimator (N=3, differential delay M=1) per channel, I and Q identical and sample-aligned.
REQ-013 Internal width SHALL be ACC_W = IN_W + 3*LOG2_DECIM (38 at defaults); integrators and combs SHALL use two's-complement modular arithmetic, wrap-around intended, no saturation.
REQ-014 Integrators SHALL be pipelined: on accepted sample (in_valid=1) int1<=int1+x, int2<=int2+int1(old), int3<=int3+int2(old); all hold when in_valid=0.
REQ-015 Decimation counter SHALL count accepted samples 0..R-1, hold when in_valid=0, and wrap to 0 on the sample accepted at count R-1.
REQ-016 The sample accepted at count R-1 SHALL raise an internal dec_strobe on the following cycle; on dec_strobe comb1 registers int3 - int3_delayed and int3_delayed<=int3.
REQ-017 Comb2 and comb3 SHALL each add one registered pipeline stage, each with its own one-decimated-sample delay register updated only by the strobe propagating through it.
REQ-018 out_valid SHALL assert for exactly one clock, 4 clocks after the edge that accepted the R-th sample; comb pipeline advances regardless of in_valid.
REQ-019 Output SHALL be comb3 arithmetically shifted right by ACC_W-OUT_W (22 at defaults), floor truncation, no rounding; DC gain = 2^(OUT_W-IN_W).
REQ-020 out_i/out_q SHALL hold their last value between out_valid strobes.
REQ-021 out_valid cadence SHALL be exactly one strobe per R accepted samples; in_valid gaps stretch, never drop or duplicate, output samples.

Reset
REQ-022 While rst_n=0 all integrators, comb and delay registers, counter, dec_strobe pipeline, out_valid, out_i, out_q SHALL be 0.
REQ-023 Reset asserted mid-decimation SHALL discard the partial frame; counting restarts from 0 on the first accepted sample after rst_n deasserts.
REQ-024 No out_valid SHALL occur in the cycle rst_n deasserts or before R samples are accepted after reset.

Structure
REQ-025 Package cic_pkg SHALL hold N_STAGES=3 and width-derivation constants (ACC_W, SHIFT = ACC_W-OUT_W) as functions of parameters.
REQ-026 Sub-module cic_channel SHALL contain one channel's integrators, combs and output shift, instantiated twice (I, Q); decimation counter and strobe pipeline SHALL live once in the top and be shared.

Verification
REQ-027 Reset then in_valid=1, in_i=+16384, in_q=-16384 constant -> out_valid every 64 clocks; from 4th strobe on out_i=+1024, out_q=-1024.
REQ-028 Full-scale DC in_i=+524287, in_q=-524288 -> settled out_i=+32767, out_q=-32768; no wrap visible at output despite integrator overflow.
REQ-029 Single-cycle gaps: in_valid low every 3rd clock, DC +16384 -> strobe after every 64 accepted samples (96 clocks), settled value still +1024.
REQ-030 Count clocks from reset release with in_valid=1 -> first out_valid exactly 4 clocks after the 64th accepted sample, then exactly 64 clocks apart.
REQ-031 Assert rst_n=0 at accepted sample 40 of a frame, release -> all outputs 0 immediately, next out_valid 4 clocks after 64 new accepted samples.
REQ-032 Random 20-bit I/Q stream, 10k samples -> out_i/out_q bit-exact against reference CIC model with identical floor truncation.
